uart_csr_master: RTL



---
 rtl/uart_csr_master.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/uart_csr_master.sv
// Host-facing CSR initiator: turns valid/ready read/write requests into CSR strobes
// and runs a background status poller with a sticky parity-error interrupt.
module uart_csr_master #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int STATUS_ADDR = 2,
    parameter int PERR_BIT    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wen,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              ren,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              poll_en,
    input  logic [15:0]       poll_period,
    output logic [DATA_W-1:0] status_q,
    output logic              err_irq,
    input  logic              err_clr
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WR        = 3'd1;
    localparam logic [2:0] S_RD        = 3'd2;
    localparam logic [2:0] S_RD_WAIT   = 3'd3;
    localparam logic [2:0] S_RSP       = 3'd4;
    localparam logic [2:0] S_POLL_RD   = 3'd5;
    localparam logic [2:0] S_POLL_WAIT = 3'd6;

    logic [2:0]        state_q, state_d;
    logic              wen_q, wen_d, ren_q, ren_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [DATA_W-1:0] status_d, status_r;
    logic              err_irq_q, err_irq_d, err_set;
    logic [15:0]       poll_cnt_q, poll_cnt_d;
    logic              poll_pending_q, poll_pending_d;
    logic              poll_active, poll_tick, poll_take;

    assign req_ready = (state_q == S_IDLE) && !poll_pending_q;
    assign wen       = wen_q;
    assign ren       = ren_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign rd_addr   = rd_addr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign status_q  = status_r;
    assign err_irq   = err_irq_q;

    // Poll timebase runs regardless of FSM state; a tick arriving while one is pending is dropped.
    always_comb begin
        poll_active = poll_en && (poll_period != 16'd0);
        poll_tick   = 1'b0;
        poll_cnt_d  = poll_cnt_q;
        if (!poll_active) begin
            poll_cnt_d = 16'd0;
        end else if (poll_cnt_q >= poll_period - 16'd1) begin
            poll_cnt_d = 16'd0;
            poll_tick  = 1'b1;
        end else begin
            poll_cnt_d = poll_cnt_q + 16'd1;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        wen_d       = 1'b0;
        ren_d       = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rd_addr_d   = rd_addr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        status_d    = status_r;
        err_set     = 1'b0;
        poll_take   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (poll_pending_q) begin
                    poll_take = 1'b1;
                    state_d   = S_POLL_RD;
                    ren_d     = 1'b1;
                    rd_addr_d = ADDR_W'(STATUS_ADDR);
                end else if (req_valid) begin
                    rsp_write_d = req_write;
                    rsp_rdata_d = '0;
                    if (req_write) begin
                        state_d   = S_WR;
                        wen_d     = 1'b1;
                        wr_addr_d = req_addr;
                        wr_data_d = req_wdata;
                    end else begin
                        state_d   = S_RD;
                        ren_d     = 1'b1;
                        rd_addr_d = req_addr;
                    end
                end
            end
            S_WR: begin
                state_d     = S_RSP;
                rsp_valid_d = 1'b1;
            end
            S_RD:      state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                state_d     = S_RSP;
                rsp_rdata_d = rd_data;
                rsp_valid_d = 1'b1;
            end
            S_RSP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            S_POLL_RD: state_d = S_POLL_WAIT;
            S_POLL_WAIT: begin
                status_d = rd_data;
                err_set  = rd_data[PERR_BIT];
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (!poll_active) begin
            poll_pending_d = 1'b0;
        end else begin
            poll_pending_d = poll_pending_q && !poll_take;
            if (poll_tick && !poll_pending_q) poll_pending_d = 1'b1;
        end

        // A set in the same cycle as a clear wins.
        err_irq_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_irq_q);
    end

    // NOTE: state is updated only with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            wen_q          <= 1'b0;
            ren_q          <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            rd_addr_q      <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_write_q    <= 1'b0;
            rsp_rdata_q    <= '0;
            status_r       <= '0;
            err_irq_q      <= 1'b0;
            poll_cnt_q     <= 16'd0;
            poll_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            wen_q          <= wen_d;
            ren_q          <= ren_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            rd_addr_q      <= rd_addr_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_write_q    <= rsp_write_d;
            rsp_rdata_q    <= rsp_rdata_d;
            status_r       <= status_d;
            err_irq_q      <= err_irq_d;
            poll_cnt_q     <= poll_cnt_d;
            poll_pending_q <= poll_pending_d;
        end
    end

endmodule
